// File: rtl/aes_engine_pkg.sv
// Shared AES-128 types, round constants and byte-level helper functions
// used by the engine datapath and the round function.
package aes_package;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } aes_engine_state_t;

    localparam logic [7:0] AES_RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] aes_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] aes_gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aes_xtime(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // S-box built from the GF(2^8) inverse (x^254, 0 maps to 0) plus the affine map
    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
        x2   = aes_gf_mul(b, b);
        x3   = aes_gf_mul(x2, b);
        x6   = aes_gf_mul(x3, x3);
        x12  = aes_gf_mul(x6, x6);
        x15  = aes_gf_mul(x12, x3);
        x30  = aes_gf_mul(x15, x15);
        x60  = aes_gf_mul(x30, x30);
        x120 = aes_gf_mul(x60, x60);
        x240 = aes_gf_mul(x120, x120);
        inv  = aes_gf_mul(aes_gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_key_expand(input logic [127:0] rk, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        logic [31:0] n0, n1, n2, n3;
        w0 = rk[127:96];
        w1 = rk[95:64];
        w2 = rk[63:32];
        w3 = rk[31:0];
        t  = {aes_sbox(w3[23:16]), aes_sbox(w3[15:8]), aes_sbox(w3[7:0]), aes_sbox(w3[31:24])}
             ^ {rcon, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/aes_engine_round.sv
// Combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Byte i of the state sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
module aes_round
    import aes_package::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         final_round_i,
    output logic [127:0] state_o
);

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        sb      = '0;
        sr      = '0;
        mc      = '0;
        state_o = '0;
        a0      = '0;
        a1      = '0;
        a2      = '0;
        a3      = '0;

        for (int unsigned i = 0; i < 16; i++) begin
            sb[127 - 8*i -: 8] = aes_sbox(state_i[127 - 8*i -: 8]);
        end

        // row r of column c takes the byte from column (c+r) mod 4
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr[127 - 8*(r + 4*c) -: 8] = sb[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end

        for (int unsigned c = 0; c < 4; c++) begin
            a0 = sr[127 - 8*(4*c)     -: 8];
            a1 = sr[127 - 8*(4*c + 1) -: 8];
            a2 = sr[127 - 8*(4*c + 2) -: 8];
            a3 = sr[127 - 8*(4*c + 3) -: 8];
            mc[127 - 8*(4*c)     -: 8] = aes_xtime(a0) ^ aes_xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[127 - 8*(4*c + 1) -: 8] = a0 ^ aes_xtime(a1) ^ aes_xtime(a2) ^ a2 ^ a3;
            mc[127 - 8*(4*c + 2) -: 8] = a0 ^ a1 ^ aes_xtime(a2) ^ aes_xtime(a3) ^ a3;
            mc[127 - 8*(4*c + 3) -: 8] = aes_xtime(a0) ^ a0 ^ a1 ^ a2 ^ aes_xtime(a3);
        end

        state_o = (final_round_i ? sr : mc) ^ rk_i;
    end

endmodule

// File: rtl/aes_engine.sv
// Iterative AES-128 encryption engine: 4-word plaintext load, 10 rounds at one
// per cycle with on-the-fly key expansion, 4-word ciphertext drain.
module aes_engine
    import aes_package::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         enable,
    input  logic         start,
    input  logic [127:0] key_i,
    input  logic         pt_valid_i,
    input  logic [31:0]  pt_data_i,
    output logic         pt_ready_o,
    output logic         ct_valid_o,
    output logic [31:0]  ct_data_o,
    input  logic         ct_ready_i,
    output logic         busy_o,
    output logic         done_o
);

    aes_engine_state_t fsm_q;
    logic [127:0]      data_q;
    logic [127:0]      key_q;
    logic [127:0]      rk_q;
    logic [3:0]        round_q;
    logic [1:0]        word_q;

    logic [127:0]      rk_d;
    logic [127:0]      data_d;
    logic              final_round;
    logic [127:0]      load_blk;

    assign final_round = (round_q == 4'd10);
    assign rk_d        = aes_key_expand(rk_q, AES_RCON[round_q - 4'd1]);
    assign load_blk    = {data_q[95:0], pt_data_i};

    aes_round u_round (
        .state_i       (data_q),
        .rk_i          (rk_d),
        .final_round_i (final_round),
        .state_o       (data_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= ST_IDLE;
            data_q  <= '0;
            key_q   <= '0;
            rk_q    <= '0;
            round_q <= '0;
            word_q  <= '0;
        end else if (clear) begin
            fsm_q   <= ST_IDLE;
            data_q  <= '0;
            key_q   <= '0;
            rk_q    <= '0;
            round_q <= '0;
            word_q  <= '0;
        end else if (enable) begin
            case (fsm_q)
                ST_IDLE: begin
                    if (start) begin
                        key_q  <= key_i;
                        word_q <= '0;
                        fsm_q  <= ST_LOAD;
                    end
                end
                // words shift in from the bottom so word 0 ends up in the top slot
                ST_LOAD: begin
                    if (pt_valid_i) begin
                        if (word_q == 2'd3) begin
                            data_q  <= load_blk ^ key_q;
                            rk_q    <= key_q;
                            round_q <= 4'd1;
                            word_q  <= '0;
                            fsm_q   <= ST_ROUND;
                        end else begin
                            data_q <= load_blk;
                            word_q <= word_q + 2'd1;
                        end
                    end
                end
                ST_ROUND: begin
                    data_q <= data_d;
                    rk_q   <= rk_d;
                    if (final_round) begin
                        round_q <= '0;
                        word_q  <= '0;
                        fsm_q   <= ST_DRAIN;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                // ciphertext shifts out of the top slot, so ct_data_o holds while stalled
                ST_DRAIN: begin
                    if (ct_ready_i) begin
                        data_q <= {data_q[95:0], 32'h0};
                        if (word_q == 2'd3) begin
                            word_q <= '0;
                            fsm_q  <= ST_DONE;
                        end else begin
                            word_q <= word_q + 2'd1;
                        end
                    end
                end
                ST_DONE: begin
                    fsm_q <= ST_IDLE;
                end
                default: begin
                    fsm_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pt_ready_o = enable && (fsm_q == ST_LOAD);
    assign ct_valid_o = enable && (fsm_q == ST_DRAIN);
    assign ct_data_o  = (fsm_q == ST_DRAIN) ? data_q[127:96] : 32'h0;
    assign busy_o     = (fsm_q != ST_IDLE);
    assign done_o     = (fsm_q == ST_DONE);

endmodule

// File: tb/tb_aes_engine.sv
// Directed bench for aes_engine: FIPS-197 vectors under stalls, key changes,
// enable freezes, clear and asynchronous reset.
module tb_aes_engine;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         clear;
    logic         enable;
    logic         start;
    logic [127:0] key_i;
    logic         pt_valid_i;
    logic [31:0]  pt_data_i;
    logic         pt_ready_o;
    logic         ct_valid_o;
    logic [31:0]  ct_data_o;
    logic         ct_ready_i;
    logic         busy_o;
    logic         done_o;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           mode;   // 0 plain, 1 key change, 2 backpressure, 3 enable stall
    } vec_t;

    vec_t vecs [4];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_engine dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .enable     (enable),
        .start      (start),
        .key_i      (key_i),
        .pt_valid_i (pt_valid_i),
        .pt_data_i  (pt_data_i),
        .pt_ready_o (pt_ready_o),
        .ct_valid_o (ct_valid_o),
        .ct_data_o  (ct_data_o),
        .ct_ready_i (ct_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job from IDLE, acting as both plaintext source and ciphertext sink.
    task automatic run_job(input vec_t v);
        int s, acc_cyc, first_ct, pi, words, stall;
        bit got_done;
        acc_cyc  = -1;
        first_ct = -1;
        pi       = 0;
        words    = 0;
        stall    = 0;
        got_done = 0;

        key_i = v.key;
        start = 1'b1;
        s     = cyc;
        tick();
        start = 1'b0;
        check("busy_after_start", {127'h0, busy_o}, 128'h1);

        for (int n = 0; n < 200; n++) begin
            pt_valid_i = (pi < 4) && ((v.mode != 2) || ($urandom_range(0, 1) == 1));
            pt_data_i  = (pi < 4) ? v.pt[32*(3 - pi) +: 32] : 32'h0;
            ct_ready_i = !((v.mode == 2) && (words == 2) && (stall < 5));
            enable     = !((v.mode == 3) && (acc_cyc >= 0) &&
                           (cyc >= acc_cyc + 5) && (cyc <= acc_cyc + 7));
            if ((v.mode == 1) && (acc_cyc >= 0) && (cyc >= acc_cyc + 3))
                key_i = ~v.key;
            #2;

            if (pt_valid_i && pt_ready_o) begin
                pi++;
                if (pi == 4) acc_cyc = cyc;
            end
            if (ct_valid_o) begin
                if (first_ct < 0) begin
                    first_ct = cyc;
                    check("ct_latency", 128'(cyc - acc_cyc), (v.mode == 3) ? 128'd14 : 128'd11);
                end
                if (words < 4)
                    check("ct_word", {96'h0, ct_data_o}, {96'h0, v.ct[32*(3 - words) +: 32]});
                if (ct_ready_i) words++;
                else stall++;
            end
            if (done_o) begin
                got_done = 1;
                check("done_no_valid", {127'h0, ct_valid_o}, 128'h0);
                if (v.mode <= 1)
                    check("start_to_done", 128'(cyc - s), 128'd19);
            end

            tick();
            if (got_done) break;
        end

        pt_valid_i = 1'b0;
        ct_ready_i = 1'b1;
        enable     = 1'b1;
        if (!got_done) check("job_timeout", 128'h0, 128'h1);
        check("words_out", 128'(words), 128'd4);
        if (v.mode == 2) check("stall_cycles", 128'(stall), 128'd5);
        check("done_one_cycle", {126'h0, done_o, busy_o}, 128'h0);
    endtask

    initial begin
        bit saw_done;
        reset_n    = 1'b0;
        clear      = 1'b0;
        enable     = 1'b1;
        start      = 1'b0;
        key_i      = '0;
        pt_valid_i = 1'b0;
        pt_data_i  = '0;
        ct_ready_i = 1'b1;
        #1;
        check("reset_outputs", {91'h0, pt_ready_o, ct_valid_o, busy_o, done_o, ct_data_o}, 128'h0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        vecs[0] = '{key: C1_KEY, pt: C1_PT, ct: C1_CT, mode: 0};
        vecs[1] = '{key: B_KEY,  pt: B_PT,  ct: B_CT,  mode: 1};
        vecs[2] = '{key: C1_KEY, pt: C1_PT, ct: C1_CT, mode: 2};
        vecs[3] = '{key: C1_KEY, pt: C1_PT, ct: C1_CT, mode: 3};

        for (int i = 0; i < 4; i++) begin
            run_job(vecs[i]);
            repeat (2) tick();
        end

        // clear after two plaintext words discards the job
        key_i = C1_KEY;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pt_valid_i = 1'b1;
            pt_data_i  = C1_PT[32*(3 - k) +: 32];
            tick();
        end
        pt_valid_i = 1'b0;
        clear      = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_idle", {126'h0, busy_o, pt_ready_o}, 128'h0);
        saw_done = 0;
        for (int k = 0; k < 25; k++) begin
            if (done_o || busy_o) saw_done = 1;
            tick();
        end
        check("clear_no_done", {127'h0, saw_done}, 128'h0);

        // clear wins over a simultaneous start
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        check("clear_beats_start", {127'h0, busy_o}, 128'h0);
        run_job('{key: C1_KEY, pt: C1_PT, ct: C1_CT, mode: 0});
        repeat (2) tick();

        // asynchronous reset in the middle of the rounds
        key_i = B_KEY;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pt_valid_i = 1'b1;
            pt_data_i  = B_PT[32*(3 - k) +: 32];
            tick();
        end
        pt_valid_i = 1'b0;
        repeat (3) tick();
        check("busy_in_round", {127'h0, busy_o}, 128'h1);
        reset_n = 1'b0;
        #1;
        check("reset_mid_round", {91'h0, pt_ready_o, ct_valid_o, busy_o, done_o, ct_data_o}, 128'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        run_job('{key: B_KEY, pt: B_PT, ct: B_CT, mode: 0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_engine.md
# aes_engine

Iterative AES-128 encryption datapath that consumes plaintext from the HWPE source streamer and produces ciphertext to the sink streamer, under control of the AES control FSM. One 128-bit block per job: collect four 32-bit plaintext words, run 10 rounds at one round per cycle with on-the-fly key expansion, then emit four 32-bit ciphertext words. Reports `busy` and a one-cycle `done` back to the FSM.

## Interface
- No parameters. AES-128 only; stream data width fixed at 32.
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous clear from FSM (`ctrl_engine.clear`)
- `enable`  in  1  clock-enable for all state; 0 freezes engine (`ctrl_engine.enable`)
- `start`  in  1  job start pulse (`ctrl_engine.start`)
- `key_i`  in  128  cipher key from register file; bit 127 = key byte 0 MSB
- `pt_valid_i`  in  1  plaintext stream valid
- `pt_data_i`  in  32  plaintext word
- `pt_ready_o`  out  1  plaintext stream ready
- `ct_valid_o`  out  1  ciphertext stream valid
- `ct_data_o`  out  32  ciphertext word
- `ct_ready_i`  in  1  ciphertext stream ready
- `busy_o`  out  1  engine not in IDLE
- `done_o`  out  1  one-cycle pulse after last ciphertext word accepted

## Operation
- States: IDLE, LOAD, ROUND, DRAIN, DONE.
- IDLE: `start`=1 (with `enable`) -> latch `key_i` into key register, word counter := 0, go LOAD. `start` outside IDLE ignored.
- LOAD: `pt_ready_o`=1. Handshake = `pt_valid_i & pt_ready_o`. Word k (0..3) fills state bits [127-32k : 96-32k] (word 0 = FIPS-197 bytes 0..3). On 4th accept: state := assembled block XOR latched key (round 0 AddRoundKey), round key := latched key, round := 1, go ROUND.
- ROUND: each cycle rk' = expand(rk, rcon[round]); state := SubBytes -> ShiftRows -> MixColumns (skipped when round==10) -> XOR rk'; rk := rk'; round++. After round 10, word counter := 0, go DRAIN.
- DRAIN: `ct_valid_o`=1, `ct_data_o` = state word k (same ordering as LOAD). Advance k on `ct_valid_o & ct_ready_i`; `ct_data_o` stable while stalled. After 4th accept go DONE.
- DONE: `done_o`=1 for one cycle, go IDLE.
- `busy_o`=1 in LOAD, ROUND, DRAIN, DONE.
- Key changes on `key_i` after start have no effect on the running job.

## Timing
- Reset: state IDLE; all outputs 0; state/key/counters 0.
- `clear` (enable-independent): next edge -> IDLE, counters 0, outputs 0; any partial block discarded, no `done_o`.
- `enable`=0: no register updates, no handshakes (`pt_ready_o`=0, `ct_valid_o`=0 while disabled); resumes exactly where frozen.
- `pt_ready_o`, `ct_valid_o`, `ct_data_o`, `done_o`, `busy_o` are functions of registered state only (no comb path from `pt_valid_i`/`ct_ready_i`).
- Latency: 4th plaintext accept in cycle T -> `ct_valid_o` high in cycle T+11 (10 ROUND cycles). Best-case job: 1 (start) + 4 + 10 + 4 + 1 = 20 cycles start-to-done.
- `reset_n` low mid-job: immediate return to reset values.
- `clear` and `start` same cycle: `clear` wins.

## Structure
- `aes_package`: `aes_engine_state_t` enum; `AES_RCON` constant array (01,02,04,08,10,20,40,80,1b,36); functions `aes_sbox(byte)`, `aes_xtime(byte)`, `aes_key_expand(rk, rcon)`.
- Sub-module `aes_round`: combinational single round (in: state, round key, `final_round`; out: next state). Engine holds FSM, counters, key/state registers.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233 44556677 8899aabb ccddeeff -> ct 69c4e0d8 6a7b0430 d8cdb780 70b4c55a, `done_o` one cycle, start-to-done 20 cycles with no stalls.
- FIPS-197 App. B: key 2b7e1516 28aed2a6 abf71588 09cf4f3c, pt 3243f6a8 885a308d 313198a2 e0370734 -> 3925841d 02dc09fb dc118597 196a0b32; change `key_i` during ROUND -> same result.
- Backpressure: random `pt_valid_i` gaps and `ct_ready_i` low for 5 cycles mid-DRAIN -> C.1 result, `ct_data_o` stable while stalled, exactly 4 words out.
- Enable stall: drop `enable` for 3 cycles at round 5 -> C.1 result, latency +3.
- `clear` after 2 plaintext words -> IDLE next cycle, no `done_o`; new C.1 job then correct.
- `reset_n` asserted in ROUND -> all outputs 0 immediately; subsequent App. B job correct.
